// File: rtl/alu_settle_unit.sv
// Sequential ALU stage feeding register A: captures B/C/func on start, waits a relay settle delay,
// then presents a registered result, flags and a one-cycle load-A request. Macro ALU_SHR_EN selects func 111.
module alu_settle_unit #(
    parameter int N             = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] c_in,
    input  logic [2:0]   func,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] alu_result,
    output logic         ld_a_req,
    output logic         flag_sign,
    output logic         flag_carry,
    output logic         flag_zero
);

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Returns {carry, result}; the carry bit is only ever set by ADD and INC.
    function automatic logic [N:0] alu_op(input logic [2:0] f, input logic [N-1:0] b, input logic [N-1:0] c);
        logic [N:0] r;
        r = '0;
        case (f)
            3'b000:  r = {1'b0, b} + {1'b0, c};
            3'b001:  r = {1'b0, b} + {{N{1'b0}}, 1'b1};
            3'b010:  r = {1'b0, b & c};
            3'b011:  r = {1'b0, b | c};
            3'b100:  r = {1'b0, b ^ c};
            3'b101:  r = {1'b0, ~b};
            3'b110:  r = {1'b0, b[N-2:0], b[N-1]};
`ifdef ALU_SHR_EN
            3'b111:  r = {1'b0, b[0], b[N-1:1]};
`else
            3'b111:  r = '0;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          capture_s;
    logic          finish_s;
    logic [N-1:0]  b_r;
    logic [N-1:0]  c_r;
    logic [2:0]    func_r;
    logic [N:0]    alu_s;
    logic [N-1:0]  result_r;
    logic          sign_r;
    logic          carry_r;
    logic          zero_r;
    logic          busy_r;
    logic          done_r;

    // Next-state and counter logic; start is only honoured in IDLE and never queued.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_LOAD;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r != '0) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // The ALU evaluates only the latched operands, so input changes mid-operation are harmless.
    always_comb begin
        alu_s = alu_op(func_r, b_r, c_r);
    end

    // Control registers: state, counter and the busy/done/load strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= finish_s;
        end
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_r    <= '0;
            c_r    <= '0;
            func_r <= 3'b000;
        end else if (capture_s) begin
            b_r    <= b_in;
            c_r    <= c_in;
            func_r <= func;
        end else begin
            b_r    <= b_r;
            c_r    <= c_r;
            func_r <= func_r;
        end
    end

    // Result and flags change only on the SETTLE->DONE edge and hold through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r <= '0;
            sign_r   <= 1'b0;
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
        end else if (finish_s) begin
            result_r <= alu_s[N-1:0];
            sign_r   <= alu_s[N-1];
            carry_r  <= alu_s[N];
            zero_r   <= (alu_s[N-1:0] == '0);
        end else begin
            result_r <= result_r;
            sign_r   <= sign_r;
            carry_r  <= carry_r;
            zero_r   <= zero_r;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign ld_a_req   = done_r;
    assign alu_result = result_r;
    assign flag_sign  = sign_r;
    assign flag_carry = carry_r;
    assign flag_zero  = zero_r;

endmodule

// File: tb/tb_alu_settle_unit.sv
// Directed and randomized bench for alu_settle_unit with an arithmetic reference model.
module tb_alu_settle_unit;

    localparam int N   = 8;
    localparam int S   = 4;
    localparam int MOD = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] b_in;
    logic [N-1:0] c_in;
    logic [2:0]   func;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] alu_result;
    logic         ld_a_req;
    logic         flag_sign;
    logic         flag_carry;
    logic         flag_zero;

    int tests = 0;
    int fails = 0;
    int exp_res = 0;
    int exp_sign = 0;
    int exp_carry = 0;
    int exp_zero = 0;

    alu_settle_unit #(.N(N), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .b_in       (b_in),
        .c_in       (c_in),
        .func       (func),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .ld_a_req   (ld_a_req),
        .flag_sign  (flag_sign),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns carry*MOD + result, computed with plain integer arithmetic.
    function automatic int model(input int b, input int c, input int f);
        int r;
        int cy;
        cy = 0;
        case (f)
            0: begin r = b + c; cy = r / MOD; r = r % MOD; end
            1: begin r = b + 1; cy = r / MOD; r = r % MOD; end
            2: r = b & c;
            3: r = b | c;
            4: r = b ^ c;
            5: r = (MOD - 1) - b;
            6: r = (b * 2) % MOD + b / (MOD / 2);
`ifdef ALU_SHR_EN
            7: r = b / 2 + (b % 2) * (MOD / 2);
`else
            7: r = 0;
`endif
            default: r = 0;
        endcase
        return cy * MOD + r;
    endfunction

    task automatic check_outputs(input string tag, input int exp_busy, input int exp_done);
        check({tag, ".busy"},  32'(busy),       exp_busy);
        check({tag, ".done"},  32'(done),       exp_done);
        check({tag, ".ld_a"},  32'(ld_a_req),   exp_done);
        check({tag, ".res"},   32'(alu_result), exp_res);
        check({tag, ".sign"},  32'(flag_sign),  exp_sign);
        check({tag, ".carry"}, 32'(flag_carry), exp_carry);
        check({tag, ".zero"},  32'(flag_zero),  exp_zero);
    endtask

    task automatic run_op(input string tag, input int b, input int c, input int f, input bit glitch);
        int m;
        m = model(b, c, f);
        b_in  = N'(b);
        c_in  = N'(c);
        func  = 3'(f);
        start = 1'b1;
        tick();
        start = 1'b0;
        b_in  = N'($urandom);
        c_in  = N'($urandom);
        func  = 3'($urandom);
        for (int k = 1; k <= S + 2; k++) begin
            if (k > 1) tick();
            if (k == S + 1) begin
                exp_res   = m % MOD;
                exp_carry = m / MOD;
                exp_zero  = (exp_res == 0) ? 1 : 0;
                exp_sign  = exp_res / (MOD / 2);
            end
            check_outputs(tag, (k <= S + 1) ? 1 : 0, (k == S + 1) ? 1 : 0);
            if (glitch && k == 2) begin
                b_in  = N'(b ^ 8'h5A);
                c_in  = N'(c ^ 8'hC3);
                func  = 3'(f ^ 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        b_in  = '0;
        c_in  = '0;
        func  = 3'b000;
        tick();
        tick();
        check_outputs("reset", 0, 0);
        rst_n = 1'b1;
        tick();
        check_outputs("idle", 0, 0);

        run_op("add7f", 8'h7F, 8'h01, 0, 1'b0);
        run_op("addff", 8'hFF, 8'h01, 0, 1'b0);
        run_op("inc10", 8'h10, 8'h00, 1, 1'b0);
        run_op("and",   8'hF0, 8'h3C, 2, 1'b0);
        run_op("or",    8'h0F, 8'h30, 3, 1'b0);
        run_op("xor",   8'hAA, 8'hFF, 4, 1'b0);
        run_op("not",   8'h0F, 8'h00, 5, 1'b0);
        run_op("shl",   8'h81, 8'h00, 6, 1'b0);
        run_op("f111",  8'h01, 8'h00, 7, 1'b0);
        run_op("incff", 8'hFF, 8'h00, 1, 1'b0);
        run_op("glitch", 8'h33, 8'h44, 0, 1'b1);
        tick();
        check_outputs("noqueue", 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                   int'($urandom_range(0, 7)), 1'b0);
        end

        // Reset arriving two edges into an operation discards it.
        run_op("prerst", 8'hC0, 8'h01, 0, 1'b0);
        b_in  = 8'h12;
        c_in  = 8'h34;
        func  = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        exp_res = 0; exp_sign = 0; exp_carry = 0; exp_zero = 0;
        check_outputs("midrst", 0, 0);
        rst_n = 1'b1;
        run_op("postrst", 8'h21, 8'h22, 0, 1'b0);

        // Reset coincident with start wins.
        rst_n = 1'b0;
        b_in  = 8'h01;
        c_in  = 8'h01;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        exp_res = 0; exp_sign = 0; exp_carry = 0; exp_zero = 0;
        check_outputs("rststart", 0, 0);
        tick();
        check_outputs("rststart2", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
